uart_core_param: RTL and testbench

- Parametrised full-duplex UART core; successor to the fixed 8N1 Uart_Interface.
- Adds configurable data width, runtime parity and stop-bit selection, and an oversampled receiver with false-start rejection.
- Adds a TX FIFO with valid/ready handshake, and parity/framing error flags.
- Sits between the system-side byte interface and the txd/rxd pins; one clock domain.

---
 rtl/uart_core_param.sv | 279 +++++++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: shared oversampling tick, TX FIFO feeding a
// frame shifter, and an oversampled receiver with parity/framing checks.
module uart_core_param #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD          = 115200,
  parameter int OVERSAMPLE    = 16,
  parameter int DATA_BITS     = 8,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic                 cfg_two_stop,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW      = $clog2(OVERSAMPLE);
  localparam int BW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int AW      = $clog2(TX_FIFO_DEPTH);
  localparam logic [OW-1:0] TICK_LAST = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] TICK_HALF = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(TX_FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DW-1:0] div_cnt_reg;
  logic          tick;
  assign tick = (div_cnt_reg == DW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) div_cnt_reg <= '0;
    else               div_cnt_reg <= div_cnt_reg + 1'b1;
  end

  logic [DATA_BITS-1:0] fifo_mem [TX_FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]          count_reg;
  logic                 fifo_full, fifo_empty, fifo_push, tx_load;
  logic [DATA_BITS-1:0] fifo_head;

  assign fifo_full  = (count_reg == FIFO_FULL);
  assign fifo_empty = (count_reg == '0);
  assign fifo_push  = tx_valid && !fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr_reg];
  assign tx_ready   = !fifo_full;

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr_reg] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (tx_load)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({fifo_push, tx_load})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Transmitter: txd is registered from the next-state decode so it stays
  // aligned with the FSM state and glitch-free on the pin.
  state_t               tx_state_reg, tx_state_next;
  logic [OW-1:0]        tx_tick_reg, tx_tick_next;
  logic [BW-1:0]        tx_bit_reg, tx_bit_next;
  logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
  logic                 tx_par_en_reg, tx_par_en_next;
  logic                 tx_two_stop_reg, tx_two_stop_next;
  logic                 tx_par_bit_reg, tx_par_bit_next;
  logic                 txd_reg, txd_next;
  logic                 tx_bit_done;

  assign tx_bit_done = tick && (tx_tick_reg == TICK_LAST);

  always_comb begin
    tx_state_next    = tx_state_reg;
    tx_tick_next     = tx_tick_reg;
    tx_bit_next      = tx_bit_reg;
    tx_shift_next    = tx_shift_reg;
    tx_par_en_next   = tx_par_en_reg;
    tx_two_stop_next = tx_two_stop_reg;
    tx_par_bit_next  = tx_par_bit_reg;
    tx_load          = 1'b0;
    if (tick) tx_tick_next = tx_bit_done ? '0 : tx_tick_reg + 1'b1;
    case (tx_state_reg)
      S_IDLE:  tx_load = !fifo_empty;
      S_START: if (tx_bit_done) begin
        tx_state_next = S_DATA;
        tx_bit_next   = '0;
      end
      S_DATA: if (tx_bit_done) begin
        tx_shift_next = {1'b0, tx_shift_reg[DATA_BITS-1:1]};
        if (tx_bit_reg == BIT_LAST) begin
          tx_state_next = tx_par_en_reg ? S_PARITY : S_STOP;
          tx_bit_next   = '0;
        end else begin
          tx_bit_next = tx_bit_reg + 1'b1;
        end
      end
      S_PARITY: if (tx_bit_done) tx_state_next = S_STOP;
      S_STOP: if (tx_bit_done) begin
        if (tx_two_stop_reg && tx_bit_reg == '0) tx_bit_next = BW'(1);
        else if (!fifo_empty)                    tx_load = 1'b1;
        else                                     tx_state_next = S_IDLE;
      end
      default: tx_state_next = S_IDLE;
    endcase
    // Loading straight from the last stop bit keeps back-to-back frames gapless.
    if (tx_load) begin
      tx_state_next    = S_START;
      tx_tick_next     = '0;
      tx_bit_next      = '0;
      tx_shift_next    = fifo_head;
      tx_par_en_next   = cfg_parity_en;
      tx_two_stop_next = cfg_two_stop;
      tx_par_bit_next  = (^fifo_head) ^ cfg_parity_odd;
    end
    case (tx_state_next)
      S_START:  txd_next = 1'b0;
      S_DATA:   txd_next = tx_shift_next[0];
      S_PARITY: txd_next = tx_par_bit_next;
      default:  txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_reg    <= S_IDLE;
      tx_tick_reg     <= '0;
      tx_bit_reg      <= '0;
      tx_shift_reg    <= '0;
      tx_par_en_reg   <= 1'b0;
      tx_two_stop_reg <= 1'b0;
      tx_par_bit_reg  <= 1'b0;
      txd_reg         <= 1'b1;
    end else begin
      tx_state_reg    <= tx_state_next;
      tx_tick_reg     <= tx_tick_next;
      tx_bit_reg      <= tx_bit_next;
      tx_shift_reg    <= tx_shift_next;
      tx_par_en_reg   <= tx_par_en_next;
      tx_two_stop_reg <= tx_two_stop_next;
      tx_par_bit_reg  <= tx_par_bit_next;
      txd_reg         <= txd_next;
    end
  end

  assign txd     = txd_reg;
  assign tx_busy = (tx_state_reg != S_IDLE) || !fifo_empty;

  // Receiver. A start needs a 1->0 edge, so after a low stop bit the line
  // must go high again before a new frame can be detected.
  logic [1:0]           rx_sync_reg;
  logic                 rx_prev_reg, rxd_s, rx_fall, rx_sample;
  state_t               rx_state_reg, rx_state_next;
  logic [OW-1:0]        rx_tick_reg, rx_tick_next;
  logic [BW-1:0]        rx_bit_reg, rx_bit_next;
  logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
  logic                 rx_par_en_reg, rx_par_en_next;
  logic                 rx_par_odd_reg, rx_par_odd_next;
  logic                 rx_perr_pend_reg, rx_perr_pend_next;
  logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
  logic                 rx_valid_reg, rx_valid_next;
  logic                 rx_perr_reg, rx_perr_next;
  logic                 rx_ferr_reg, rx_ferr_next;

  assign rxd_s     = rx_sync_reg[1];
  assign rx_fall   = rx_prev_reg && !rxd_s;
  assign rx_sample = tick && (rx_tick_reg == ((rx_state_reg == S_START) ? TICK_HALF : TICK_LAST));

  always_comb begin
    rx_state_next     = rx_state_reg;
    rx_tick_next      = rx_tick_reg;
    rx_bit_next       = rx_bit_reg;
    rx_shift_next     = rx_shift_reg;
    rx_par_en_next    = rx_par_en_reg;
    rx_par_odd_next   = rx_par_odd_reg;
    rx_perr_pend_next = rx_perr_pend_reg;
    rx_data_next      = rx_data_reg;
    rx_valid_next     = 1'b0;
    rx_perr_next      = 1'b0;
    rx_ferr_next      = 1'b0;
    if (tick) rx_tick_next = rx_sample ? '0 : rx_tick_reg + 1'b1;
    case (rx_state_reg)
      S_IDLE: begin
        rx_tick_next = '0;
        if (rx_fall) begin
          rx_state_next     = S_START;
          rx_par_en_next    = cfg_parity_en;
          rx_par_odd_next   = cfg_parity_odd;
          rx_perr_pend_next = 1'b0;
        end
      end
      S_START: if (rx_sample) begin
        rx_state_next = rxd_s ? S_IDLE : S_DATA;
        rx_bit_next   = '0;
      end
      S_DATA: if (rx_sample) begin
        rx_shift_next = {rxd_s, rx_shift_reg[DATA_BITS-1:1]};
        if (rx_bit_reg == BIT_LAST) begin
          rx_state_next = rx_par_en_reg ? S_PARITY : S_STOP;
          rx_bit_next   = '0;
        end else begin
          rx_bit_next = rx_bit_reg + 1'b1;
        end
      end
      S_PARITY: if (rx_sample) begin
        rx_perr_pend_next = rxd_s ^ (^rx_shift_reg) ^ rx_par_odd_reg;
        rx_state_next     = S_STOP;
      end
      S_STOP: if (rx_sample) begin
        rx_valid_next = 1'b1;
        rx_data_next  = rx_shift_reg;
        rx_perr_next  = rx_perr_pend_reg;
        rx_ferr_next  = !rxd_s;
        rx_state_next = S_IDLE;
      end
      default: rx_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync_reg      <= 2'b11;
      rx_prev_reg      <= 1'b1;
      rx_state_reg     <= S_IDLE;
      rx_tick_reg      <= '0;
      rx_bit_reg       <= '0;
      rx_shift_reg     <= '0;
      rx_par_en_reg    <= 1'b0;
      rx_par_odd_reg   <= 1'b0;
      rx_perr_pend_reg <= 1'b0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rx_perr_reg      <= 1'b0;
      rx_ferr_reg      <= 1'b0;
    end else begin
      rx_sync_reg      <= {rx_sync_reg[0], rxd};
      rx_prev_reg      <= rxd_s;
      rx_state_reg     <= rx_state_next;
      rx_tick_reg      <= rx_tick_next;
      rx_bit_reg       <= rx_bit_next;
      rx_shift_reg     <= rx_shift_next;
      rx_par_en_reg    <= rx_par_en_next;
      rx_par_odd_reg   <= rx_par_odd_next;
      rx_perr_pend_reg <= rx_perr_pend_next;
      rx_data_reg      <= rx_data_next;
      rx_valid_reg     <= rx_valid_next;
      rx_perr_reg      <= rx_perr_next;
      rx_ferr_reg      <= rx_ferr_next;
    end
  end

  assign rx_data       = rx_data_reg;
  assign rx_valid      = rx_valid_reg;
  assign rx_parity_err = rx_perr_reg;
  assign rx_frame_err  = rx_ferr_reg;

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param at 16 clocks per bit; received words are
// checked against a queue of expected results filled as stimulus is driven.
module tb_uart_core_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_parity_en, cfg_parity_odd, cfg_two_stop;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_busy, txd;
  logic       rxd, rxd_drv, loop_en;
  logic [7:0] rx_data;
  logic       rx_valid, rx_parity_err, rx_frame_err;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   rx_count = 0;

  always #5 clk = ~clk;
  assign rxd = loop_en ? txd : rxd_drv;

  uart_core_param #(
    .CLK_FREQ(50_000_000), .BAUD(3_125_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .TX_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd), .cfg_two_stop(cfg_two_stop),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy), .txd(txd),
    .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Receive-side scoreboard: every rx_valid pulse must match the oldest entry.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_count++;
      $display("rx word %02h perr %0b ferr %0b", rx_data, rx_parity_err, rx_frame_err);
      check("rx_expected_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(mon_e.d));
        check("rx_parity_err", 32'(rx_parity_err), 32'(mon_e.pe));
        check("rx_frame_err", 32'(rx_frame_err), 32'(mon_e.fe));
      end
    end
  end

  task automatic push(input logic [7:0] d, input bit expect_rx);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    if (expect_rx) sb_q.push_back({d, 1'b0, 1'b0});
    $display("tx push %02h", d);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_sb_empty(input int max_cycles);
    int t = 0;
    while (sb_q.size() != 0 && t < max_cycles) begin
      @(negedge clk);
      t++;
    end
    check("sb_drain", 32'(sb_q.size()), 32'd0);
  endtask

  // Samples each txd bit at its midpoint, then measures start edge to tx_busy drop.
  task automatic tx_frame_check(input logic [7:0] d, input logic pe, input logic po,
                                input logic ts, input int exp_len);
    int   t = 0;
    int   n = 0;
    int   nb;
    logic eb;
    while (txd !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("tx_start_seen", 32'(txd), 32'd0);
    nb = 10 + int'(pe) + int'(ts);
    for (int k = 0; k < nb; k++) begin
      while (n < 16 * k + 8) begin
        @(negedge clk);
        n++;
      end
      if (k == 0)            eb = 1'b0;
      else if (k <= 8)       eb = d[k-1];
      else if (k == 9 && pe) eb = (^d) ^ po;
      else                   eb = 1'b1;
      check($sformatf("txd_bit%0d", k), 32'(txd), 32'(eb));
    end
    while (tx_busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("tx_frame_len", 32'(n), 32'(exp_len));
  endtask

  task automatic send_rx(input logic [7:0] d, input logic pe, input logic pbit, input logic sbit);
    $display("rx drive %02h pe %0b pbit %0b stop %0b", d, pe, pbit, sbit);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      repeat (16) @(negedge clk);
    end
    if (pe) begin
      rxd_drv = pbit;
      repeat (16) @(negedge clk);
    end
    rxd_drv = sbit;
    repeat (16) @(negedge clk);
  endtask

  int accepted;
  int blen;
  int snap;

  initial begin
    reset = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; rxd_drv = 1'b1; loop_en = 1'b1;
    cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_two_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_tx_ready", 32'(tx_ready), 32'd1);
    check("reset_tx_busy", 32'(tx_busy), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_errs", 32'({rx_parity_err, rx_frame_err}), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 loopback
    push(8'hA5, 1'b1);
    tx_frame_check(8'hA5, 1'b0, 1'b0, 1'b0, 160);
    wait_sb_empty(100);

    // Even then odd parity, then odd parity with two stop bits
    cfg_parity_en = 1'b1;
    push(8'h07, 1'b1);
    tx_frame_check(8'h07, 1'b1, 1'b0, 1'b0, 176);
    wait_sb_empty(100);
    cfg_parity_odd = 1'b1;
    push(8'h07, 1'b1);
    tx_frame_check(8'h07, 1'b1, 1'b1, 1'b0, 176);
    wait_sb_empty(100);
    cfg_two_stop = 1'b1;
    push(8'hE1, 1'b1);
    tx_frame_check(8'hE1, 1'b1, 1'b1, 1'b1, 192);
    wait_sb_empty(100);

    // Directly driven RX: wrong parity, then low stop bit
    loop_en = 1'b0; cfg_parity_odd = 1'b0; cfg_two_stop = 1'b0;
    repeat (20) @(negedge clk);
    sb_q.push_back({8'h3C, 1'b1, 1'b0});
    send_rx(8'h3C, 1'b1, 1'b1, 1'b1);
    wait_sb_empty(100);
    sb_q.push_back({8'h3C, 1'b0, 1'b1});
    send_rx(8'h3C, 1'b1, 1'b0, 1'b0);
    wait_sb_empty(100);
    snap = rx_count;
    repeat (100) @(negedge clk);
    check("no_rearm_while_low", 32'(rx_count), 32'(snap));
    rxd_drv = 1'b1;
    repeat (32) @(negedge clk);
    cfg_parity_en = 1'b0;
    sb_q.push_back({8'h55, 1'b0, 1'b0});
    send_rx(8'h55, 1'b0, 1'b0, 1'b1);
    wait_sb_empty(100);

    // False start: 4-clock glitch must not produce a word
    snap = rx_count;
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (60) @(negedge clk);
    check("false_start_no_pulse", 32'(rx_count), 32'(snap));
    sb_q.push_back({8'h55, 1'b0, 1'b0});
    send_rx(8'h55, 1'b0, 1'b0, 1'b1);
    wait_sb_empty(100);

    // FIFO depth and back-to-back transmission
    loop_en = 1'b1;
    repeat (20) @(negedge clk);
    fork
      begin
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (tx_ready !== 1'b1) break;
          tx_data  = 8'(accepted * 37 + 5);
          tx_valid = 1'b1;
          sb_q.push_back({8'(accepted * 37 + 5), 1'b0, 1'b0});
          $display("tx push %02h", 8'(accepted * 37 + 5));
          accepted++;
        end
        tx_valid = 1'b0;
      end
      begin
        int t = 0;
        while (txd !== 1'b0 && t < 50) begin
          @(negedge clk);
          t++;
        end
        blen = 0;
        while (tx_busy === 1'b1 && blen < 1200) begin
          @(negedge clk);
          blen++;
        end
      end
    join
    check("fifo_accepted", 32'(accepted), 32'd5);
    check("burst_len", 32'(blen), 32'd800);
    wait_sb_empty(200);
    check("burst_tx_ready", 32'(tx_ready), 32'd1);
    check("burst_tx_busy", 32'(tx_busy), 32'd0);

    // Reset mid-frame with a second word queued
    push(8'hC3, 1'b0);
    push(8'h3C, 1'b0);
    repeat (64) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_txd", 32'(txd), 32'd1);
    check("midreset_tx_ready", 32'(tx_ready), 32'd1);
    check("midreset_tx_busy", 32'(tx_busy), 32'd0);
    check("midreset_rx_valid", 32'(rx_valid), 32'd0);
    reset = 1'b0;
    snap = rx_count;
    repeat (400) @(negedge clk);
    check("midreset_no_rx", 32'(rx_count), 32'(snap));
    check("midreset_txd_idle", 32'(txd), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
